// File: rtl/seg7_scan_reader_if.sv
// Frame handshake bundle between seg7_scan_reader and its downstream consumer.
// The master side produces recovered frames; the slave side accepts them.
interface seg7_scan_reader_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   err;
  logic              valid;
  logic              ready;
  logic              overrun;

  modport master (output data, output err, output valid, output overrun, input ready);
  modport slave  (input data, input err, input valid, input overrun, output ready);
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed 7-segment bus back into hex digits and delivers each
// fully refreshed set of digits as one frame over a valid/ready handshake.
module seg7_scan_reader #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a,
  input  logic              i_b,
  input  logic              i_c,
  input  logic              i_d,
  input  logic              i_e,
  input  logic              i_f,
  input  logic              i_g,
  input  logic [NDIG-1:0]   i_dig_en,
  seg7_scan_reader_if.master o_frame
);

  localparam int SW = NDIG + 7;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE - 1);

  logic [SW-1:0]     r_smp;
  logic [CW-1:0]     r_cnt;
  logic [NDIG-1:0]   r_seen;
  logic [4*NDIG-1:0] r_slotData;
  logic [NDIG-1:0]   r_slotErr;
  logic [4*NDIG-1:0] r_data;
  logic [NDIG-1:0]   r_err;
  logic              r_valid;
  logic              r_overrun;

  logic [SW-1:0] w_smpNext;
  logic          w_changed;
  logic          w_oneHot;
  logic          w_capture;
  logic [4:0]    w_dec;
  logic          w_frameDone;
  logic          w_load;

  // Inverse of the display's hex decode; returns {err, nibble}.
  function automatic logic [4:0] decodeSeg(input logic [6:0] p);
    case (p)
      7'h7E:   return 5'h00;
      7'h30:   return 5'h01;
      7'h6D:   return 5'h02;
      7'h79:   return 5'h03;
      7'h33:   return 5'h04;
      7'h5B:   return 5'h05;
      7'h5F:   return 5'h06;
      7'h70:   return 5'h07;
      7'h7F:   return 5'h08;
      7'h7B:   return 5'h09;
      7'h77:   return 5'h0A;
      7'h1F:   return 5'h0B;
      7'h4E:   return 5'h0C;
      7'h3D:   return 5'h0D;
      7'h4F:   return 5'h0E;
      7'h47:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  assign w_smpNext   = {i_dig_en, i_a, i_b, i_c, i_d, i_e, i_f, i_g};
  assign w_changed   = (w_smpNext != r_smp);
  assign w_oneHot    = $onehot(w_smpNext[SW-1:7]);
  // Only the STABLE-1 -> STABLE step captures, so a saturated dwell captures once.
  assign w_capture   = !w_changed && w_oneHot && (r_cnt == CNT_CAP);
  assign w_dec       = decodeSeg(r_smp[6:0]);
  assign w_frameDone = &r_seen;
  assign w_load      = w_frameDone && (!r_valid || o_frame.ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp <= '0;
      r_cnt <= '0;
    end else begin
      r_smp <= w_smpNext;
      if (w_changed || !w_oneHot) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slotData <= '0;
      r_slotErr  <= '0;
      r_seen     <= '0;
    end else begin
      if (w_capture) begin
        for (int i = 0; i < NDIG; i++) begin
          if (r_smp[7+i]) begin
            r_slotData[4*i +: 4] <= w_dec[3:0];
            r_slotErr[i]         <= w_dec[4];
          end
        end
      end
      r_seen <= (w_frameDone ? '0 : r_seen) | (w_capture ? r_smp[SW-1:7] : '0);
    end
  end

  // A completed frame is dropped only when the previous one is still unconsumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_err     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_frameDone && !w_load;
      if (w_load) begin
        r_data  <= r_slotData;
        r_err   <= r_slotErr;
        r_valid <= 1'b1;
      end else if (r_valid && o_frame.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_frame.data    = r_data;
  assign o_frame.err     = r_err;
  assign o_frame.valid   = r_valid;
  assign o_frame.overrun = r_overrun;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scans plus random dwells, checked by a
// scoreboard fed from a dwell-level reference model.
module tb_seg7_scan_reader;
  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  typedef struct packed {
    logic [4*NDIG-1:0] data;
    logic [NDIG-1:0]   err;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            a, b, c, d, e, f, g;
  logic [NDIG-1:0] digEn;

  seg7_scan_reader_if #(.NDIG(NDIG)) frameIf ();

  seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst(rst),
    .i_a(a), .i_b(b), .i_c(c), .i_d(d), .i_e(e), .i_f(f), .i_g(g),
    .i_dig_en(digEn),
    .o_frame(frameIf)
  );

  always #5 clk = ~clk;

  frame_t          expQ[$];
  frame_t          monExp;
  int              checks = 0;
  int              fails = 0;
  int              overrunSeen = 0;
  int              expOverrun = 0;
  logic [6:0]      refPat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0]      mNib [NDIG];
  logic            mErr [NDIG];
  logic [NDIG-1:0] mSeen;
  logic [NDIG+6:0] prevVec;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Dwell-level model: a one-hot dwell of at least STABLE+1 edges captures one digit.
  task automatic modelDwell(input logic [NDIG-1:0] en, input logic [6:0] seg, input int len,
                            input logic consume);
    int     idx;
    frame_t fr;
    idx = 0;
    fr  = '0;
    if ($countones(en) == 1 && len >= STABLE + 1) begin
      for (int i = 0; i < NDIG; i++) if (en[i]) idx = i;
      mNib[idx] = 4'h0;
      mErr[idx] = 1'b1;
      for (int p = 0; p < 16; p++) begin
        if (refPat[p] == seg) begin
          mNib[idx] = 4'(p);
          mErr[idx] = 1'b0;
        end
      end
      mSeen[idx] = 1'b1;
      if (mSeen == '1) begin
        mSeen = '0;
        for (int i = 0; i < NDIG; i++) begin
          fr.data[4*i +: 4] = mNib[i];
          fr.err[i]         = mErr[i];
        end
        if (!consume && expQ.size() > 0) expOverrun++;
        else expQ.push_back(fr);
      end
    end
  endtask

  task automatic setVec(input logic [NDIG-1:0] en, input logic [6:0] seg);
    {digEn, a, b, c, d, e, f, g} = {en, seg};
    prevVec = {en, seg};
  endtask

  task automatic applyStimulus(input logic [NDIG-1:0] en, input logic [6:0] seg, input int len);
    modelDwell(en, seg, len, frameIf.ready);
    setVec(en, seg);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    expQ.delete();
    mSeen = '0;
    for (int i = 0; i < NDIG; i++) begin
      mNib[i] = 4'h0;
      mErr[i] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frameIf.overrun) overrunSeen++;
      if (frameIf.valid && frameIf.ready) begin
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpectedFrame: actual data=%0h err=%0h required no frame",
                   frameIf.data, frameIf.err);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("frameData", frameIf.data, monExp.data);
          checkOutput("frameErr", frameIf.err, monExp.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int firstValid;
    int validCycles;
    logic [NDIG-1:0] en;
    logic [6:0] seg;
    int len;
    int kind;
    int x;

    rst = 1'b1;
    frameIf.ready = 1'b1;
    setVec('0, 7'h00);
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", frameIf.valid, 0);
    checkOutput("resetData", frameIf.data, 0);
    checkOutput("resetErr", frameIf.err, 0);
    checkOutput("resetOverrun", frameIf.overrun, 0);
    rst = 1'b0;

    // 1234 scan with latency measurement on the last digit
    applyStimulus(4'b0001, refPat[4], 6);
    applyStimulus(4'b0010, refPat[3], 6);
    applyStimulus(4'b0100, refPat[2], 6);
    modelDwell(4'b1000, refPat[1], 6, frameIf.ready);
    setVec(4'b1000, refPat[1]);
    firstValid = 0;
    validCycles = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (frameIf.valid) begin
        if (firstValid == 0) begin
          firstValid = k;
          checkOutput("frame1234", frameIf.data, 16'h1234);
        end
        validCycles++;
      end
    end
    checkOutput("validLatency", firstValid, STABLE + 2);
    checkOutput("validWidth", validCycles, 1);

    // all sixteen legal codes, then illegal codes
    for (int blk = 0; blk < 4; blk++)
      for (int dg = 0; dg < NDIG; dg++)
        applyStimulus(4'(1 << dg), refPat[blk*4 + dg], STABLE + 1 + int'($urandom_range(0, 2)));
    applyStimulus(4'b0001, 7'h00, 5);
    applyStimulus(4'b0010, 7'h7C, 5);
    applyStimulus(4'b0100, refPat[5], 5);
    applyStimulus(4'b1000, 7'h7C, 5);

    // short dwell and multi-hot on the last missing digit must not complete a frame
    applyStimulus(4'b0001, refPat[9], 7);
    applyStimulus(4'b0010, refPat[10], 5);
    applyStimulus(4'b0100, refPat[11], 5);
    applyStimulus(4'b1000, refPat[12], STABLE);
    applyStimulus(4'b0000, 7'h00, 2);
    applyStimulus(4'b0011, refPat[1], 10);
    applyStimulus(4'b1100, refPat[2], 10);
    checkOutput("noEarlyFrame", frameIf.valid, 0);
    applyStimulus(4'b1000, refPat[13], 5);
    repeat (2) @(posedge clk);
    #1;

    // backpressure: first frame held, second dropped with one overrun pulse
    frameIf.ready = 1'b0;
    for (int dg = 0; dg < NDIG; dg++) applyStimulus(4'(1 << dg), refPat[5 + dg], STABLE + 2);
    checkOutput("bpValid", frameIf.valid, 1);
    checkOutput("bpData", frameIf.data, 16'h8765);
    for (int dg = 0; dg < NDIG; dg++) begin
      applyStimulus(4'(1 << dg), refPat[9 + dg], STABLE + 2);
      checkOutput("bpHold", frameIf.data, 16'h8765);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bpOverrun", overrunSeen, expOverrun);
    checkOutput("bpOverrunOne", overrunSeen, 1);
    frameIf.ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bpConsumed", frameIf.valid, 0);

    // consume and completion on the same edge
    frameIf.ready = 1'b0;
    for (int dg = 0; dg < NDIG; dg++) applyStimulus(4'(1 << dg), refPat[(13 + dg) % 16], STABLE + 2);
    for (int dg = 0; dg < NDIG - 1; dg++) applyStimulus(4'(1 << dg), refPat[1 + dg], STABLE + 2);
    modelDwell(4'b1000, refPat[4], STABLE + 3, 1'b1);
    setVec(4'b1000, refPat[4]);
    repeat (STABLE + 1) @(posedge clk);
    #1;
    frameIf.ready = 1'b1;
    @(posedge clk);
    #1;
    frameIf.ready = 1'b0;
    checkOutput("sameEdgeValid", frameIf.valid, 1);
    checkOutput("sameEdgeData", frameIf.data, 16'h4321);
    checkOutput("sameEdgeOverrun", overrunSeen, expOverrun);
    @(posedge clk);
    #1;
    frameIf.ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("sameEdgeDrained", frameIf.valid, 0);

    // reset mid-dwell while a frame is pending and a partial frame is collected
    frameIf.ready = 1'b0;
    for (int dg = 0; dg < NDIG; dg++) applyStimulus(4'(1 << dg), refPat[2 + 2*dg], STABLE + 2);
    applyStimulus(4'b0001, refPat[1], 5);
    applyStimulus(4'b0010, refPat[3], 5);
    setVec(4'b0100, refPat[5]);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    setVec('0, 7'h00);
    resetModel();
    #1;
    checkOutput("midResetValid", frameIf.valid, 0);
    checkOutput("midResetData", frameIf.data, 0);
    checkOutput("midResetErr", frameIf.err, 0);
    checkOutput("midResetOverrun", frameIf.overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    frameIf.ready = 1'b1;
    applyStimulus(4'b0100, refPat[7], 5);
    applyStimulus(4'b1000, refPat[9], 5);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("noStaleSeen", frameIf.valid, 0);
    applyStimulus(4'b0001, refPat[10], 5);
    applyStimulus(4'b0010, refPat[11], 5);
    repeat (2) @(posedge clk);
    #1;

    // random dwells: legal, raw, short, blank and multi-hot
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(0, 9));
      x    = int'($urandom_range(0, NDIG - 1));
      en   = 4'(1 << x);
      seg  = refPat[$urandom_range(0, 15)];
      len  = STABLE + 1 + int'($urandom_range(0, 3));
      if (kind == 6) len = int'($urandom_range(1, STABLE));
      if (kind == 7) begin
        en  = '0;
        len = int'($urandom_range(1, 3));
      end
      if (kind == 8) en = en | 4'(1 << ((x + 1 + int'($urandom_range(0, NDIG - 2))) % NDIG));
      if (kind == 9) seg = 7'($urandom_range(0, 127));
      if ({en, seg} == prevVec) seg = seg ^ 7'h01;
      applyStimulus(en, seg, len);
    end
    setVec('0, 7'h00);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("overrunTotal", overrunSeen, expOverrun);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
